// File: rtl/ann_pkg.sv
// Shared ANN-layer types.
// Word width and dot-product sequencer states.
package ann_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mat_vec_sequencer.sv
// Computes y = M*x one row at a time by driving
// a shared dot-product engine and collecting scalars.
module mat_vec_sequencer
  import ann_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = ann_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mat [ROWS][COLS],
  input  logic [DATA_W-1:0] vec [COLS],
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result [ROWS],
  output logic [DATA_W-1:0] dp_vec1 [COLS],
  output logic [DATA_W-1:0] dp_vec2 [COLS],
  output logic              dp_start,
  input  logic [DATA_W-1:0] dp_result,
  input  logic              dp_done
);

  localparam int RW =
    (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST =
    RW'(ROWS - 1);

  seq_state_t        state;
  seq_state_t        state_n;
  logic [RW-1:0]     row;
  logic              accept;
  logic              capture;
  logic [DATA_W-1:0] mat_q [ROWS][COLS];
  logic [DATA_W-1:0] vec_q [COLS];

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // dp_done is only meaningful here
        if (dp_done) begin
          capture = 1'b1;
          state_n = (row == LAST) ? DONE : ISSUE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      row    <= '0;
      mat_q  <= '{default: '{default: '0}};
      vec_q  <= '{default: '0};
      result <= '{default: '0};
    end else begin
      state <= state_n;
      if (accept) begin
        mat_q <= mat;
        vec_q <= vec;
        row   <= '0;
      end
      if (capture) begin
        result[row] <= dp_result;
        if (row != LAST) begin
          row <= row + 1'b1;
        end
      end
    end
  end

  assign busy     = (state == ISSUE) ||
                    (state == WAIT);
  assign done     = (state == DONE);
  assign dp_start = (state == ISSUE);
  assign dp_vec1  = mat_q[row];
  assign dp_vec2  = vec_q;

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Scoreboard bench for mat_vec_sequencer with
// behavioural dot-product engines of programmable latency.
module tb_mat_vec_sequencer;
  import ann_pkg::*;

  typedef struct packed {
    logic [3:0][31:0] r;
    logic [31:0]      cyc;
  } exp_a_t;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] cyc;
  } exp_b_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  exp_a_t qa[$];
  exp_b_t qb[$];

  // ---------------- DUT A: 4x4 ----------------
  logic        start_a;
  logic [31:0] mat_a [4][4];
  logic [31:0] vec_a [4];
  logic        busy_a, done_a;
  logic [31:0] result_a [4];
  logic [31:0] dp_vec1_a [4];
  logic [31:0] dp_vec2_a [4];
  logic        dp_start_a;
  logic [31:0] dp_result_a;
  logic        dp_done_a;

  mat_vec_sequencer #(.ROWS(4), .COLS(4), .DATA_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .mat(mat_a), .vec(vec_a),
    .busy(busy_a), .done(done_a), .result(result_a),
    .dp_vec1(dp_vec1_a), .dp_vec2(dp_vec2_a),
    .dp_start(dp_start_a), .dp_result(dp_result_a),
    .dp_done(dp_done_a)
  );

  // ---------------- DUT B: 1x4 ----------------
  logic        start_b;
  logic [31:0] mat_b [1][4];
  logic [31:0] vec_b [4];
  logic        busy_b, done_b;
  logic [31:0] result_b [1];
  logic [31:0] dp_vec1_b [4];
  logic [31:0] dp_vec2_b [4];
  logic        dp_start_b;
  logic [31:0] dp_result_b;
  logic        dp_done_b;

  mat_vec_sequencer #(.ROWS(1), .COLS(4), .DATA_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .mat(mat_b), .vec(vec_b),
    .busy(busy_b), .done(done_b), .result(result_b),
    .dp_vec1(dp_vec1_b), .dp_vec2(dp_vec2_b),
    .dp_start(dp_start_b), .dp_result(dp_result_b),
    .dp_done(dp_done_b)
  );

  // ---------------- engine models ----------------
  int          lat_a = 1;
  bit          ovr_a = 1'b0;
  bit          stray_a = 1'b0;
  int          cnt_a = 0;
  logic        eng_done_a = 1'b0;
  logic [31:0] eng_res_a = '0;
  int          nstart_a = 0;

  always @(posedge clk) begin : eng_a
    logic [31:0] s;
    eng_done_a <= 1'b0;
    if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) eng_done_a <= 1'b1;
    end
    if (dp_start_a) begin
      nstart_a <= nstart_a + 1;
      s = '0;
      for (int j = 0; j < 4; j++) s = s + dp_vec1_a[j] * dp_vec2_a[j];
      eng_res_a <= ovr_a ? 32'hFFFF_FFFF : s;
      if (lat_a <= 1) eng_done_a <= 1'b1;
      else cnt_a <= lat_a - 1;
    end
  end

  assign dp_done_a   = eng_done_a | stray_a;
  assign dp_result_a = stray_a ? 32'hDEAD_BEEF : eng_res_a;

  int          lat_b = 1;
  int          cnt_b = 0;
  logic        eng_done_b = 1'b0;
  logic [31:0] eng_res_b = '0;

  always @(posedge clk) begin : eng_b
    logic [31:0] s;
    eng_done_b <= 1'b0;
    if (cnt_b > 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) eng_done_b <= 1'b1;
    end
    if (dp_start_b) begin
      s = '0;
      for (int j = 0; j < 4; j++) s = s + dp_vec1_b[j] * dp_vec2_b[j];
      eng_res_b <= s;
      if (lat_b <= 1) eng_done_b <= 1'b1;
      else cnt_b <= lat_b - 1;
    end
  end

  assign dp_done_b   = eng_done_b;
  assign dp_result_b = eng_res_b;

  // ---------------- helpers ----------------
  function automatic void check(string name, logic [127:0] act,
                                logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] v4(input logic [31:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [127:0] pk4(input logic [31:0] a [4]);
    return {a[3], a[2], a[1], a[0]};
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, want 0",
               qa.size() + qb.size());
    end
    @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    exp_a_t e;
    if (done_a) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_a_unexpected: got done at cycle %0d, want none",
                 cyc);
      end else begin
        e = qa.pop_front();
        check("result_a", pk4(result_a), e.r);
        check("done_cycle_a", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_b_t e;
    if (done_b) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_b_unexpected: got done at cycle %0d, want none",
                 cyc);
      end else begin
        e = qb.pop_front();
        check("result_b", 128'(result_b[0]), 128'(e.r));
        check("done_cycle_b", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n0;
    int t0;
    start_a = 1'b0;
    start_b = 1'b0;
    mat_a   = '{default: '{default: '0}};
    vec_a   = '{default: '0};
    mat_b   = '{default: '{default: '0}};
    vec_b   = '{default: '0};

    repeat (3) @(negedge clk);
    check("rst_ctrl_a", 128'({busy_a, done_a, dp_start_a}), 128'(0));
    check("rst_result_a", pk4(result_a), '0);
    check("rst_dpvec_a", pk4(dp_vec1_a) | pk4(dp_vec2_a), '0);
    check("rst_b", 128'({busy_b, done_b, dp_start_b, result_b[0]}),
          128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Identity, L=1
    mat_a = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
    vec_a = '{1, 2, 3, 4};
    lat_a = 1;
    n0 = nstart_a;
    start_a = 1'b1;
    qa.push_back(exp_a_t'{r: v4(1, 2, 3, 4), cyc: cyc + 9});
    @(negedge clk);
    start_a = 1'b0;
    drain(100);
    check("dp_start_count", 128'(nstart_a - n0), 128'(4));

    // Mixed rows, L=3, busy window
    mat_a = '{'{1, 1, 1, 1}, '{2, 2, 2, 2}, '{0, 0, 0, 0}, '{1, 2, 3, 4}};
    vec_a = '{1, 1, 1, 1};
    lat_a = 3;
    start_a = 1'b1;
    qa.push_back(exp_a_t'{r: v4(4, 8, 0, 10), cyc: cyc + 17});
    for (int k = 0; k < 19; k++) begin
      check($sformatf("busy_c%0d", k), 128'(busy_a),
            128'(k >= 1 && k <= 16));
      @(negedge clk);
      if (k == 0) start_a = 1'b0;
    end
    drain(100);

    // Stray dp_done in IDLE must not write
    stray_a = 1'b1;
    @(negedge clk);
    stray_a = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_idle_result", pk4(result_a), v4(4, 8, 0, 10));
    check("stray_idle_busy", 128'(busy_a), 128'(0));

    // start held high, operands changed mid-run
    mat_a = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
    vec_a = '{1, 2, 3, 4};
    lat_a = 1;
    start_a = 1'b1;
    qa.push_back(exp_a_t'{r: v4(1, 2, 3, 4), cyc: cyc + 9});
    qa.push_back(exp_a_t'{r: v4(8, 8, 8, 8), cyc: cyc + 19});
    repeat (3) @(negedge clk);
    mat_a = '{default: '{default: 32'd2}};
    vec_a = '{default: 32'd1};
    repeat (9) @(negedge clk);
    start_a = 1'b0;
    drain(100);

    // Full-width pass-through
    ovr_a = 1'b1;
    lat_a = 2;
    mat_a = '{'{3, 1, 4, 1}, '{5, 9, 2, 6}, '{5, 3, 5, 8}, '{9, 7, 9, 3}};
    start_a = 1'b1;
    qa.push_back(exp_a_t'{r: {4{32'hFFFF_FFFF}}, cyc: cyc + 13});
    @(negedge clk);
    start_a = 1'b0;
    drain(100);
    ovr_a = 1'b0;

    // Reset during WAIT of row 2, engine answers 2 cycles later
    mat_a = '{'{1, 1, 1, 1}, '{2, 2, 2, 2}, '{0, 0, 0, 0}, '{1, 2, 3, 4}};
    vec_a = '{1, 1, 1, 1};
    lat_a = 4;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_pre_busy", 128'(busy_a), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 14; k <= 20; k++) begin
      check($sformatf("abort_ctrl_c%0d", k),
            128'({busy_a, done_a, dp_start_a}), 128'(0));
      check($sformatf("abort_result_c%0d", k), pk4(result_a), '0);
      if (k == 14)
        check("abort_dpvec", pk4(dp_vec1_a) | pk4(dp_vec2_a), '0);
      if (k == 15)
        check("abort_engine_done", 128'(dp_done_a), 128'(1));
      @(negedge clk);
    end

    // ROWS=1 boundary, L=2
    mat_b = '{'{1, 0, 0, 1}};
    vec_b = '{5, 5, 5, 5};
    lat_b = 2;
    start_b = 1'b1;
    qb.push_back(exp_b_t'{r: 32'd10, cyc: cyc + 4});
    @(negedge clk);
    start_b = 1'b0;
    drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mat_vec_sequencer.md
Name: mat_vec_sequencer

Overview:
Initiator side of the vector-vector-to-scalar protocol. Computes y = M·x, one row at a time, by issuing a sequence of dot-product requests to an external dot-product engine and collecting the returned scalars into a result vector. Sits between a dense ANN layer controller and one shared dot-product engine.

Parameters:
ROWS, 4, number of matrix rows (output vector length); ≥1
COLS, 4, vector length per dot product (engine VECTOR_LEN); ≥1
DATA_W, 32, element/scalar width (fixed 32 in package; parameter for checking only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
mat  input  DATA_W x [ROWS][COLS]  weight matrix; captured on accepted start
vec  input  DATA_W x [COLS]  input vector; captured on accepted start
busy  output  1  high in ISSUE/WAIT
done  output  1  single-cycle pulse; result valid
result  output  DATA_W x [ROWS]  registered output vector
dp_vec1  output  DATA_W x [COLS]  row of captured matrix, current row
dp_vec2  output  DATA_W x [COLS]  captured vector
dp_start  output  1  single-cycle request pulse to engine
dp_result  input  DATA_W  engine scalar; valid when dp_done=1
dp_done  input  1  engine completion pulse; latency L ≥1 cycles after dp_start

Behaviour:
- One clock; reset synchronous, active-high. On rst: state=IDLE, row=0, busy=0, done=0, dp_start=0, result all 0, captured mat/vec all 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: start=1 → capture mat/vec, row=0, go ISSUE. Otherwise stay.
- ISSUE (one cycle): dp_start=1. dp_vec1=mat_q[row], dp_vec2=vec_q; both are stable from ISSUE through WAIT. Next state WAIT.
- WAIT: hold until dp_done=1. Then result[row] <= dp_result. If row==ROWS-1 go DONE, else row++ and go ISSUE.
- DONE (one cycle): done=1, busy=0, then IDLE. start during DONE is ignored.
- start while busy: ignored; captured operands are not disturbed.
- dp_done outside WAIT (stray, or post-reset leftover): ignored; no result write.
- Latency: start sampled at cycle 0 → done at cycle ROWS*(L+1)+1. Row period is L+1.
- result: entries update as rows complete and hold after done until the next accepted start overwrites them row by row. result is only guaranteed coherent on done and afterwards.
- Reset mid-operation: abort immediately and apply all reset values. No done pulse. The engine may still return dp_done, which is ignored in IDLE.
- Arithmetic: none locally. Scalars are passed through at DATA_W bits; overflow handling belongs to the engine.
- row counter width: $clog2(ROWS), min 1. The ROWS=1 boundary must work (ISSUE→WAIT→DONE).

Decomposition:
- Shared package ann_pkg: DATA_W=32, typedef word_t (logic [31:0]), enum seq_state_t {IDLE, ISSUE, WAIT, DONE}.
- No sub-module. Row select mux, counter and FSM live inline. The bench instantiates a behavioural engine model with programmable L.

Test Plan:
- Identity M=I4, x={1,2,3,4}, L=1, start at cycle 0 → done at cycle 9, result={1,2,3,4}, exactly 4 dp_start pulses.
- M rows {1,1,1,1},{2,2,2,2},{0,0,0,0},{1,2,3,4}, x={1,1,1,1}, L=3 → done at cycle 17, result={4,8,0,10}, busy high cycles 1–16.
- start held high continuously plus new mat/vec driven mid-run → single run, result from values captured at cycle 0, next run begins on the cycle after DONE returns to IDLE.
- rst asserted during WAIT of row 2 with engine dp_done arriving 2 cycles later → all outputs 0, no done pulse, stray dp_done leaves result=0.
- ROWS=1, COLS=4, x={5,5,5,5}, M={1,0,0,1}, L=2 → done at cycle 4, result={10}.
- dp_result=0xFFFFFFFF on every row → result all 0xFFFFFFFF (full-width pass-through, no truncation).
